// File: rtl/mul_div_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_pkg                                                   |
// | Purpose  : Shared definitions for the multiply/divide unit: datapath     |
// |            width, iteration count, counter width and the controller     |
// |            state encoding.                                               |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
package mul_div_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;

   // Adder width: one guard bit above the operand width.
   localparam int ADD_W = WIDTH + 1;

   // Counter holds 0..ITER-1 with headroom.
   localparam int CNT_W = $clog2(ITER) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage : mul_div_pkg
`default_nettype wire

// File: rtl/mul_div_addsub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_addsub                                               |
// | Purpose  : 33-bit adder/subtractor shared by the Booth multiply and      |
// |            restoring divide iterations.                                  |
// | Ports    : a, b  - ADD_W-bit operands                                    |
// |            sub   - 1: sum = a - b, 0: sum = a + b                        |
// |            sum   - ADD_W-bit result                                      |
// |            cout  - carry out; for subtraction 1 means no borrow (a >= b) |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module mul_div_addsub
   import mul_div_pkg::*;
(
   input  logic [ADD_W-1:0] a,
   input  logic [ADD_W-1:0] b,
   input  logic             sub,
   output logic [ADD_W-1:0] sum,
   output logic             cout
);

   logic [ADD_W-1:0] b_eff;

   assign b_eff = b ^ {ADD_W{sub}};

   // Two's-complement subtract: a + ~b + 1.
   assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{ADD_W{1'b0}}, sub};

endmodule : mul_div_addsub
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_unit                                                  |
// | Purpose  : Iterative signed 32x32 multiply (radix-2 Booth, 64-bit       |
// |            product) and signed divide (restoring on magnitudes with a    |
// |            sign fix-up step). Fixed 33-cycle latency from acceptance.    |
// | Ports    : clk         - clock, rising edge                              |
// |            clr_n       - asynchronous active-low reset                   |
// |            start       - request, sampled only in IDLE                   |
// |            MUL, DIV    - one-hot operation select                        |
// |            A, B        - signed operands (multiplicand/dividend, ...)    |
// |            busy        - operation in progress                           |
// |            done        - one-cycle pulse when HI/LO are updated          |
// |            HI, LO      - result pair (product hi/lo, remainder/quotient) |
// |            div_by_zero - last completed DIV had B = 0                    |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module mul_div_unit
   import mul_div_pkg::*;
(
   input  logic             clk,
   input  logic             clr_n,
   input  logic             start,
   input  logic             MUL,
   input  logic             DIV,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;

   // Shared work register.
   //   MUL: 65-bit Booth product register {upper, multiplier, q(-1)}.
   //   DIV: bit 64 unused (0), [63:32] partial remainder, [31:0] quotient.
   logic [2*WIDTH:0]    acc;
   logic [2*WIDTH:0]    acc_nxt;
   logic [WIDTH-1:0]    opnd;       // multiplicand (MUL) or |divisor| (DIV)
   logic                op_mul;
   logic                sign_a;
   logic                sign_b;
   logic                b_zero;

   logic                accept;
   logic [WIDTH-1:0]    abs_a;
   logic [WIDTH-1:0]    abs_b;

   logic [ADD_W-1:0]    add_a;
   logic [ADD_W-1:0]    add_b;
   logic                add_sub;
   logic [ADD_W-1:0]    add_sum;
   logic                add_cout;

   logic [WIDTH-1:0]    res_hi;
   logic [WIDTH-1:0]    res_lo;

   assign accept = (state == IDLE) && start && (MUL ^ DIV);
   assign busy   = (state != IDLE);
   assign abs_a  = A[WIDTH-1] ? -A : A;
   assign abs_b  = B[WIDTH-1] ? -B : B;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (cnt == LAST_ITER) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------ shared adder
   mul_div_addsub u_addsub (
      .a    (add_a),
      .b    (add_b),
      .sub  (add_sub),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_sub = 1'b0;
      acc_nxt = acc;
      if (op_mul) begin
         // Booth pair {q0, q-1}: 01 adds, 10 subtracts the multiplicand.
         // The upper field is sign-extended to 33 bits so that subtracting
         // -2^31 cannot overflow before the arithmetic shift.
         add_a   = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
         add_b   = (acc[1] ^ acc[0]) ? {opnd[WIDTH-1], opnd} : '0;
         add_sub = (acc[1:0] == 2'b10);
         // Arithmetic shift right by one; the 33-bit sum's top bit becomes
         // the new sign, its lower bits fill the upper field and bit 32.
         acc_nxt = {add_sum, acc[WIDTH:1]};
      end else begin
         // Shift {R, Q} left by one and trial-subtract the divisor.
         add_a   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
         add_b   = {1'b0, opnd};
         add_sub = 1'b1;
         acc_nxt = {1'b0,
                    add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0],
                    acc[WIDTH-2:0],
                    add_cout};
      end
   end

   // ----------------------------------------------------- result fix-up
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      if (op_mul) begin
         res_hi = acc[2*WIDTH:WIDTH+1];
         res_lo = acc[WIDTH:1];
      end else begin
         // With a zero divisor the quotient is all ones from the iterations
         // and must not be negated; the remainder then equals A.
         res_lo = (b_zero || (sign_a == sign_b)) ? acc[WIDTH-1:0]
                                                 : -acc[WIDTH-1:0];
         res_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt         <= '0;
         acc         <= '0;
         opnd        <= '0;
         op_mul      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         b_zero      <= 1'b0;
         done        <= 1'b0;
         HI          <= '0;
         LO          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  op_mul <= MUL;
                  sign_a <= A[WIDTH-1];
                  sign_b <= B[WIDTH-1];
                  b_zero <= (B == '0);
                  if (MUL) begin
                     acc  <= {{WIDTH{1'b0}}, B, 1'b0};
                     opnd <= A;
                  end else begin
                     acc  <= {1'b0, {WIDTH{1'b0}}, abs_a};
                     opnd <= abs_b;
                  end
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + CNT_W'(1);
            end
            FIX: begin
               HI          <= res_hi;
               LO          <= res_lo;
               div_by_zero <= !op_mul && b_zero;
               done        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_div_unit                                               |
// | Purpose  : Self-checking bench for mul_div_unit: directed cases plus    |
// |            randomized operations compared against an arithmetic model.  |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module tb_mul_div_unit;

   logic        clk;
   logic        clr_n;
   logic        start;
   logic        MUL;
   logic        DIV;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        div_by_zero;

   int n_checks = 0;
   int n_pass   = 0;

   mul_div_unit dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .start       (start),
      .MUL         (MUL),
      .DIV         (DIV),
      .A           (A),
      .B           (B),
      .busy        (busy),
      .done        (done),
      .HI          (HI),
      .LO          (LO),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Arithmetic reference: 64-bit signed product, truncating division.
   function automatic void model(input logic is_mul, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] hi,
                                 output logic [31:0] lo, output logic dz);
      longint pa, pb, p, q, r;
      pa = longint'(signed'(a));
      pb = longint'(signed'(b));
      dz = 1'b0;
      if (is_mul) begin
         p  = pa * pb;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
         dz = 1'b1;
      end else begin
         q  = pa / pb;
         r  = pa % pb;
         lo = q[31:0];
         hi = r[31:0];
      end
   endfunction

   // Issue one operation and follow it to completion.
   task automatic do_op(input logic is_mul, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez,
                        input bit noise);
      logic [31:0] h0, l0;
      logic        d0;
      int          lat;
      bit          held, bsy_ok;
      h0 = HI; l0 = LO; d0 = div_by_zero;
      @(negedge clk);
      start = 1'b1; MUL = is_mul; DIV = !is_mul; A = a; B = b;
      @(posedge clk); #1;
      start = 1'b0;
      A = $urandom; B = $urandom; MUL = $urandom_range(0, 1); DIV = $urandom_range(0, 1);
      check("busy_after_accept", busy, 1);
      lat = 0; held = 1; bsy_ok = 1;
      while (!done && lat < 40) begin
         if (HI !== h0 || LO !== l0 || div_by_zero !== d0) held = 0;
         if (!busy) bsy_ok = 0;
         if (noise) begin
            start = $urandom_range(0, 1);
            MUL = $urandom_range(0, 1); DIV = $urandom_range(0, 1);
            A = $urandom; B = $urandom;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("latency", lat, 33);
      check("outputs_held", held, 1);
      check("busy_during", bsy_ok, 1);
      check("HI", HI, eh);
      check("LO", LO, el);
      check("div_by_zero", div_by_zero, ez);
      check("busy_at_done", busy, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
   endtask

   task automatic rand_op();
      logic [31:0] a, b, eh, el;
      logic        ez, m;
      case ($urandom_range(0, 4))
         0: a = 32'h8000_0000;
         1: a = 32'hFFFF_FFFF;
         2: a = 32'd0;
         default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
         0: b = 32'h8000_0000;
         1: b = 32'hFFFF_FFFF;
         2: b = 32'd0;
         3: b = $urandom_range(1, 9);
         default: b = $urandom;
      endcase
      m = $urandom_range(0, 1);
      model(m, a, b, eh, el, ez);
      do_op(m, a, b, eh, el, ez, 1'b1);
   endtask

   task automatic bad_start(input logic m, input logic d);
      logic [31:0] h0, l0;
      logic        d0;
      bit          quiet;
      h0 = HI; l0 = LO; d0 = div_by_zero; quiet = 1;
      @(negedge clk);
      start = 1'b1; MUL = m; DIV = d; A = $urandom; B = $urandom;
      repeat (4) begin
         @(posedge clk); #1;
         if (busy || done || HI !== h0 || LO !== l0 || div_by_zero !== d0) quiet = 0;
      end
      start = 1'b0;
      check("ignored_bad_select", quiet, 1);
   endtask

   initial begin
      bit saw_done;
      clr_n = 1'b0; start = 1'b0; MUL = 1'b0; DIV = 1'b0; A = '0; B = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_HI", HI, 0);
      check("rst_LO", LO, 0);
      check("rst_dbz", div_by_zero, 0);
      @(negedge clk); clr_n = 1'b1;

      // Directed cases.
      do_op(1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
      do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
      do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      do_op(1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
      do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);
      bad_start(1'b1, 1'b1);
      bad_start(1'b0, 1'b0);

      // Abort: second start ignored, reset mid-operation, no done.
      @(negedge clk);
      start = 1'b1; MUL = 1'b1; DIV = 1'b0; A = 32'd123; B = 32'd456;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      start = 1'b1; MUL = 1'b0; DIV = 1'b1; A = 32'd99; B = 32'd3;
      @(posedge clk); #1; start = 1'b0;
      check("busy_second_start", busy, 1);
      repeat (10) @(posedge clk);
      #1 clr_n = 1'b0;
      #1;
      check("abort_HI", HI, 0);
      check("abort_LO", LO, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      saw_done = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      check("no_done_after_abort", saw_done, 0);
      do_op(1'b1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

      // Randomized operations against the model.
      repeat (40) rand_op();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_mul_div_unit
`default_nettype wire
